inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch reader for SIC-4, the consumer side of the PC interface. Accepts fetch addresses from the `pc` block via a valid/ready handshake and issues reads to synchronous instruction memory with 1-cycle read latency. Buffers returned instruction words with their addresses in an internal FIFO and presents them to decode through a second valid/ready handshake. Supports flush for branch redirects.

## Interface
- `ADDR_W`, default 8: PC/memory address width.
- `INST_W`, default 16: instruction word width.
- `DEPTH`, default 4: output FIFO entries; power of two; ≥3 for full throughput.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pc`  in  ADDR_W  fetch address.
- `pc_valid`  in  1  `pc` holds a fetch request.
- `pc_ready`  out  1  fetch unit accepts the request this cycle.
- `flush`  in  1  discard all buffered and in-flight fetches.
- `mem_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rdata`  in  INST_W  read data, valid the cycle after `mem_en`.
- `inst`  out  INST_W  instruction at FIFO head.
- `inst_pc`  out  ADDR_W  address of `inst`.
- `inst_valid`  out  1  FIFO non-empty.
- `inst_ready`  in  1  decode consumes head this cycle.

## Operation
- Registered state: FIFO storage (`inst`+`pc` pairs), rd/wr pointers, `count` (0..DEPTH), `inflight` flag with captured address `inflight_pc`.
- Accept = `pc_valid & pc_ready`. `pc_ready = !flush & (count + inflight < DEPTH)`; it depends only on registered state and `flush`, never on `inst_ready`.
- `mem_en = accept`, `mem_addr = pc` (combinational pass-through). On accept, set `inflight`=1 and `inflight_pc`=`pc`; otherwise clear `inflight`.
- If `inflight` is set, `mem_rdata` is pushed together with `inflight_pc` into the FIFO tail.
- Pop = `inst_valid & inst_ready`; advances the head. Push and pop in the same cycle leave `count` unchanged. Pointers wrap modulo DEPTH.
- Outputs `inst`/`inst_pc` are driven from the head entry. They are don't-care while `inst_valid`=0, but must stay stable while `inst_valid & !inst_ready`.
- Push while full cannot occur; the `pc_ready` rule guarantees this. Assert in simulation.
- `flush`: next cycle `count`=0, pointers=0, `inflight`=0. A push due in the flush cycle is dropped. No accept occurs in the flush cycle. Pop in the flush cycle is still honoured by decode but has no further effect.
- Reset (`rst_n`=0 at edge): `count`=0, pointers=0, `inflight`=0. This yields `inst_valid`=0 and `pc_ready`=1 (when not flushing), `mem_en`=0 with `pc_valid` low. `inst` and `inst_pc` reset to 0. Reset mid-operation discards everything, as flush does. Reset has priority over flush.

## Timing
- Accept at cycle N → `mem_rdata` sampled at N+1 → `inst_valid` at N+2 (2-cycle latency) with `inst_pc`=accepted `pc`.
- With DEPTH≥3 and `inst_ready` held high: one accept and one delivery per cycle, sustained.
- Fill with `inst_ready`=0: DEPTH accepts, then `pc_ready` drops. The cycle after the first pop, `pc_ready` returns to 1.
- In-order delivery; no reordering, no duplication.

## Configuration
- `INST_FETCH_STATS_EN` defined: adds output `fetch_count` [15:0]. It resets to 0, increments on every pop, and wraps 0xFFFF→0. It is not cleared by `flush`.
- Undefined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset, then `pc_valid`=1 with `pc`=0x00,0x01,0x02… each cycle, `inst_ready`=1, memory returns `{8'hA5,addr}` → `inst`=0xA500,0xA501… from cycle 2, one per cycle, `inst_pc` matches.
- Same stream with `inst_ready`=0 → exactly 4 accepts (`mem_addr` 0x00–0x03), then `pc_ready`=0. Raise `inst_ready` → 0xA500..0xA503 delivered in order, accepts resume.
- `flush` asserted 1 cycle after accepting 0x10 and 0x11 (one buffered, one in flight) → `inst_valid`=0 next cycle. A subsequent fetch of 0x40 delivers `inst_pc`=0x40 with no stale 0x10/0x11.
- `rst_n`=0 while FIFO holds 3 entries → next cycle `inst_valid`=0, `pc_ready`=1, `inst`=0, `inst_pc`=0.
- Address wrap: fetch 0xFE,0xFF,0x00 → delivered in that order. FIFO pointer wrap exercised over more than 8 entries without loss.
- With `INST_FETCH_STATS_EN`: 5 pops → `fetch_count`=5. Preload 0xFFFF, then pop → 0x0000.

Source files
------------

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: groups the fetch unit's handshakes into one bundle.
//
//   pc side     : pc, pc_valid -> fetch unit; pc_ready <- fetch unit; flush -> fetch unit
//   memory side : mem_en, mem_addr <- fetch unit; mem_rdata -> fetch unit (1-cycle latency)
//   decode side : inst, inst_pc, inst_valid <- fetch unit; inst_ready -> fetch unit
//
// Modports:
//   master : the environment (pc block, instruction memory, decode)
//   slave  : the fetch unit itself
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned INST_W = 16
);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_rdata;

    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;

    modport master (
        output pc, pc_valid, flush, mem_rdata, inst_ready,
        input  pc_ready, mem_en, mem_addr, inst, inst_pc, inst_valid
    );

    modport slave (
        input  pc, pc_valid, flush, mem_rdata, inst_ready,
        output pc_ready, mem_en, mem_addr, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch reader for SIC-4.
//
// Accepts fetch addresses from the pc block (valid/ready), issues a read to a
// synchronous instruction memory (1-cycle latency), buffers each returned word
// with its address in a DEPTH-entry FIFO and presents the FIFO head to decode
// (valid/ready). flush discards everything buffered or in flight.
//
// Ports:
//   clk         : clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset (priority over flush)
//   bus         : inst_fetch_if.slave (pc / memory / decode handshakes, flush)
//   fetch_count : [15:0] pop counter, present only with INST_FETCH_STATS_EN
//
// Optional feature macro: INST_FETCH_STATS_EN adds fetch_count, which counts
// every pop (wrapping at 16 bits) and survives flush.
module inst_fetch #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned INST_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    inst_fetch_if.slave bus
`ifdef INST_FETCH_STATS_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough to hold DEPTH itself (count ranges 0..DEPTH).
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_fetch: DEPTH must be a power of two and at least 2");
    end

    // FIFO storage: instruction word plus the address it was fetched from.
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;

    logic [CntW-1:0]   occupancy;
    logic              accept;
    logic              push;
    logic              pop;

    // pc_ready reserves a slot for the read still in flight, so the word
    // returning next cycle always has room and pc_ready never looks at
    // inst_ready.
    always_comb begin
        occupancy     = count_q + CntW'(inflight_q);
        bus.pc_ready  = !bus.flush && (occupancy < CntW'(DEPTH));
        accept        = bus.pc_valid && bus.pc_ready;
        bus.mem_en    = accept;
        bus.mem_addr  = bus.pc;

        bus.inst_valid = (count_q != '0);
        bus.inst       = inst_mem_q[rd_ptr_q];
        bus.inst_pc    = pc_mem_q[rd_ptr_q];

        push = inflight_q;
        pop  = bus.inst_valid && bus.inst_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            // Storage is cleared so the head (entry 0) reads as zero after reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (bus.flush) begin
            // Drops the push due this cycle; a pop this cycle has no effect.
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                inflight_pc_q <= bus.pc;
            end
            if (push) begin
                inst_mem_q[wr_ptr_q] <= bus.mem_rdata;
                pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
                wr_ptr_q             <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef INST_FETCH_STATS_EN
    // Counts pops including one taken in a flush cycle; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (pop) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // The slot reservation in pc_ready makes a push into a full FIFO impossible.
    always @(posedge clk) begin
        if (rst_n && !bus.flush) begin
            assert (!(push && count_q == CntW'(DEPTH)));
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a
// queue-based reference model (list of accepted addresses awaiting delivery).
module tb_inst_fetch;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INST_W = 16;
    localparam int unsigned DEPTH  = 4;

    logic clk;
    logic rst_n;

    inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

`ifdef INST_FETCH_STATS_EN
    logic [15:0] fetch_count;
`endif

    inst_fetch #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef INST_FETCH_STATS_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data for the address presented last cycle, junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= {8'hA5, bus.mem_addr};
        else            bus.mem_rdata <= 16'hDEAD;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: addresses whose words are buffered, plus the one in flight.
    logic [7:0]  fifo_q[$];
    logic        m_inflight;
    logic [7:0]  m_inflight_pc;
    logic        just_reset;
    logic [15:0] m_pops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input logic v, input logic [7:0] a, input logic rdy, input logic fl,
                       input logic rn, output logic acc);
        logic m_ready;
        logic m_pop;
        @(negedge clk);
        bus.pc_valid   = v;
        bus.pc         = a;
        bus.inst_ready = rdy;
        bus.flush      = fl;
        rst_n          = rn;
        #1;
        m_ready = !fl && ((fifo_q.size() + (m_inflight ? 1 : 0)) < DEPTH);
        acc     = v && m_ready;
        m_pop   = (fifo_q.size() != 0) && rdy;
        chk("pc_ready", 32'(bus.pc_ready), 32'(m_ready));
        chk("mem_en", 32'(bus.mem_en), 32'(acc));
        if (acc) chk("mem_addr", 32'(bus.mem_addr), 32'(a));
        chk("inst_valid", 32'(bus.inst_valid), 32'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            chk("inst_pc", 32'(bus.inst_pc), 32'(fifo_q[0]));
            chk("inst", 32'(bus.inst), 32'({8'hA5, fifo_q[0]}));
        end
        if (just_reset) begin
            chk("inst_rst", 32'(bus.inst), 32'h0);
            chk("inst_pc_rst", 32'(bus.inst_pc), 32'h0);
            just_reset = 1'b0;
        end
`ifdef INST_FETCH_STATS_EN
        chk("fetch_count", 32'(fetch_count), 32'(m_pops));
`endif
        @(posedge clk);
        if (!rn) begin
            fifo_q.delete();
            m_inflight = 1'b0;
            m_pops     = '0;
            just_reset = 1'b1;
        end else begin
            if (m_pop) m_pops = m_pops + 16'd1;
            if (fl) begin
                fifo_q.delete();
                m_inflight = 1'b0;
            end else begin
                if (m_pop) void'(fifo_q.pop_front());
                if (m_inflight) fifo_q.push_back(m_inflight_pc);
                m_inflight    = acc;
                m_inflight_pc = a;
            end
        end
    endtask

    initial begin
        logic       acc;
        logic [7:0] nxt;
        int         n_acc;

        rst_n          = 1'b0;
        bus.pc_valid   = 1'b0;
        bus.pc         = '0;
        bus.inst_ready = 1'b0;
        bus.flush      = 1'b0;
        fifo_q.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_pops        = '0;
        just_reset    = 1'b1;
        repeat (2) @(posedge clk);

        // Streaming with decode always ready, more than 2*DEPTH entries.
        nxt = 8'h00;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, nxt, 1'b1, 1'b0, 1'b1, acc);
            if (acc) nxt++;
        end
        chk("stream_accepts", 32'(nxt), 32'd12);
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);

        // Fill with decode stalled: exactly DEPTH accepts, then release.
        nxt   = 8'h00;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, nxt, 1'b0, 1'b0, 1'b1, acc);
            if (acc) begin
                nxt++;
                n_acc++;
            end
        end
        chk("fill_accepts", 32'(n_acc), 32'(DEPTH));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, nxt, 1'b1, 1'b0, 1'b1, acc);
            if (acc) nxt++;
        end
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);

        // Flush with one entry buffered and one in flight.
        cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 8'h12, 1'b0, 1'b1, 1'b1, acc);
        chk("flush_no_accept", 32'(acc), 32'd0);
        cyc(1'b1, 8'h40, 1'b1, 1'b0, 1'b1, acc);
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);

        // Reset with three entries held.
        cyc(1'b1, 8'h20, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 8'h21, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        chk("held_before_reset", 32'(fifo_q.size()), 32'd3);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Address wrap.
        cyc(1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, acc);
        cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, acc);
        cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, acc);
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);

`ifdef INST_FETCH_STATS_EN
        // Five pops after a fresh reset.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b1, acc);
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
        chk("five_pops", 32'(fetch_count), 32'd5);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                ($urandom % 25) == 0, ($urandom % 80) != 0, acc);
        end
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
        chk("drained", 32'(bus.inst_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
